// File: rtl/fp_add_pkg.sv
// Shared definitions for the FP add/subtract arbiter: FSM encoding,
// datapath width and operation-select codes.
package fp_add_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/fp_add.sv
// Combinational IEEE-754 single-precision add/subtract unit.
// Round-to-nearest-even, gradual underflow, overflow to infinity,
// any NaN input (or inf - inf) yields the canonical quiet NaN 0x7FC00000.
module fp_add
    import fp_add_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  op_sym,
    output logic [DATA_WIDTH-1:0] result
);

    logic        sign_a, sign_b;
    logic [7:0]  exp_a, exp_b;
    logic [22:0] frac_a, frac_b;
    logic        nan_a, nan_b, inf_a, inf_b;
    logic        a_is_larger;

    logic        sx, sy;
    logic [7:0]  ex, ey, diff;
    logic [23:0] mx, my;
    logic [26:0] x_ext, y_ext, y_al, lost;
    logic [27:0] sum;

    logic [4:0]  lz;
    logic [7:0]  shift;
    logic [26:0] norm;
    logic [8:0]  exp_n;
    logic        round_up;
    logic [31:0] rounded;

    // Subtraction is an addition with operand B's sign flipped.
    assign sign_a      = a[31];
    assign sign_b      = b[31] ^ (op_sym == OP_SUB);
    assign exp_a       = a[30:23];
    assign exp_b       = b[30:23];
    assign frac_a      = a[22:0];
    assign frac_b      = b[22:0];
    assign nan_a       = (exp_a == 8'hFF) && (frac_a != 23'd0);
    assign nan_b       = (exp_b == 8'hFF) && (frac_b != 23'd0);
    assign inf_a       = (exp_a == 8'hFF) && (frac_a == 23'd0);
    assign inf_b       = (exp_b == 8'hFF) && (frac_b == 23'd0);
    assign a_is_larger = (a[30:0] >= b[30:0]);

    // Order operands by magnitude, align the smaller one (keeping G/R/sticky) and add.
    always_comb begin
        sx    = sign_b;
        sy    = sign_a;
        ex    = (exp_b == 8'd0) ? 8'd1 : exp_b;
        ey    = (exp_a == 8'd0) ? 8'd1 : exp_a;
        mx    = {exp_b != 8'd0, frac_b};
        my    = {exp_a != 8'd0, frac_a};
        if (a_is_larger) begin
            sx = sign_a;
            sy = sign_b;
            ex = (exp_a == 8'd0) ? 8'd1 : exp_a;
            ey = (exp_b == 8'd0) ? 8'd1 : exp_b;
            mx = {exp_a != 8'd0, frac_a};
            my = {exp_b != 8'd0, frac_b};
        end
        diff  = ex - ey;
        x_ext = {mx, 3'b000};
        y_ext = {my, 3'b000};
        lost  = '0;
        if (diff >= 8'd27) begin
            y_al = {26'd0, |y_ext};
        end else begin
            y_al    = y_ext >> diff;
            lost    = y_ext & ~({27{1'b1}} << diff);
            y_al[0] = y_al[0] | (|lost);
        end
        if (sx == sy) begin
            sum = {1'b0, x_ext} + {1'b0, y_al};
        end else begin
            sum = {1'b0, x_ext} - {1'b0, y_al};
        end
    end

    // Normalise (clamped at the subnormal boundary), round to nearest even, pack.
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (sum[i]) begin
                lz = 5'(26 - i);
            end
        end
        shift = 8'd0;
        if (sum[27]) begin
            norm  = sum[27:1] | {26'd0, sum[0]};
            exp_n = {1'b0, ex} + 9'd1;
        end else begin
            shift = ({3'b000, lz} < ex) ? {3'b000, lz} : (ex - 8'd1);
            norm  = sum[26:0] << shift;
            exp_n = {1'b0, ex - shift};
            if (!norm[26]) begin
                exp_n = 9'd0;
            end
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        // A mantissa carry from rounding ripples naturally into the exponent field.
        rounded  = {exp_n, norm[25:3]} + {31'd0, round_up};

        if (nan_a || nan_b || (inf_a && inf_b && (sign_a != sign_b))) begin
            result = 32'h7FC0_0000;
        end else if (inf_a) begin
            result = {sign_a, 8'hFF, 23'd0};
        end else if (inf_b) begin
            result = {sign_b, 8'hFF, 23'd0};
        end else if (sum == 28'd0) begin
            result = {sx & sy, 31'd0};
        end else if (rounded[31:23] >= 9'd255) begin
            result = {sx, 8'hFF, 23'd0};
        end else begin
            result = {sx, rounded[30:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester with req set,
// searching upward from ptr with wrap-around. Outputs one-hot and encoded grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    int              idx;
    logic [ID_W-1:0] idx_sel;
    logic            found;

    // Walk the requesters starting at ptr; the first one asserted wins.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        found   = 1'b0;
        idx     = 0;
        idx_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_sel = ID_W'(idx);
            if (!found && req[idx_sel]) begin
                found        = 1'b1;
                gnt[idx_sel] = 1'b1;
                gnt_id       = idx_sel;
            end
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one FP add/subtract unit between NUM_REQ requesters.
// Operands and result are registered around the adder. Optional statistics
// counters (op_count, grant_count) are built when FP_ADD_ARB_STATS_EN is defined.
module fp_add_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_symbol,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_W-1:0]               rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_out,
    output logic                          busy
`ifdef FP_ADD_ARB_STATS_EN
    ,
    output logic [15:0]                   op_count,
    output logic [NUM_REQ*8-1:0]          grant_count
`endif
);
    import fp_add_pkg::*;

    state_t                state_reg, state_next;
    logic [ID_W-1:0]       rr_ptr_reg;
    logic [DATA_WIDTH-1:0] op_a_reg, op_b_reg;
    logic                  op_sym_reg;
    logic [ID_W-1:0]       op_id_reg;

    logic [NUM_REQ-1:0]    gnt;
    logic [ID_W-1:0]       gnt_id;
    logic                  hs_req, rsp_load, rsp_done;
    logic [DATA_WIDTH-1:0] add_result;
    logic [DATA_WIDTH-1:0] a_lane [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_lane [NUM_REQ];

    genvar gi;

    // Split the flat operand buses into per-requester lanes.
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign a_lane[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
        assign b_lane[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (rr_ptr_reg),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    fp_add u_add (
        .a      (op_a_reg),
        .b      (op_b_reg),
        .op_sym (op_sym_reg),
        .result (add_result)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake strobes; grants are only offered in IDLE.
    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        hs_req     = 1'b0;
        rsp_load   = 1'b0;
        rsp_done   = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = gnt;
                if (|(req_valid & gnt)) begin
                    hs_req     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                rsp_load   = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (rsp_ready) begin
                    rsp_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE);

    // Operand capture, round-robin pointer advance and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
            op_a_reg   <= '0;
            op_b_reg   <= '0;
            op_sym_reg <= 1'b0;
            op_id_reg  <= '0;
            rsp_out    <= '0;
            rsp_id     <= '0;
            rsp_valid  <= 1'b0;
        end else begin
            if (hs_req) begin
                op_a_reg   <= a_lane[gnt_id];
                op_b_reg   <= b_lane[gnt_id];
                op_sym_reg <= req_symbol[gnt_id];
                op_id_reg  <= gnt_id;
                rr_ptr_reg <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            end
            if (rsp_load) begin
                rsp_out   <= add_result;
                rsp_id    <= op_id_reg;
                rsp_valid <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef FP_ADD_ARB_STATS_EN
    logic [7:0] grant_cnt_reg [NUM_REQ];

    // Completed-response counter, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_count <= 16'd0;
        end else if (rsp_done && (op_count != 16'hFFFF)) begin
            op_count <= op_count + 16'd1;
        end
    end

    for (gi = 0; gi < NUM_REQ; gi++) begin : g_grant_cnt
        // Per-requester wrap-around count of accepted requests.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grant_cnt_reg[gi] <= 8'd0;
            end else if (hs_req && gnt[gi]) begin
                grant_cnt_reg[gi] <= grant_cnt_reg[gi] + 8'd1;
            end
        end
        assign grant_count[gi*8 +: 8] = grant_cnt_reg[gi];
    end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: vector table, hand-written corner
// sequences and a randomized run against a transaction-level reference model.
// Statistics checks are included when FP_ADD_ARB_STATS_EN is defined.
module tb_fp_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int ID_W    = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NUM_REQ-1:0]    req_valid, req_ready, req_symbol;
    logic [NUM_REQ*DW-1:0] req_a, req_b;
    logic                  rsp_valid, rsp_ready, busy;
    logic [ID_W-1:0]       rsp_id;
    logic [DW-1:0]         rsp_out;
`ifdef FP_ADD_ARB_STATS_EN
    logic [15:0]           op_count;
    logic [NUM_REQ*8-1:0]  grant_count;
`endif

    fp_add_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_symbol (req_symbol),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_out    (rsp_out),
        .busy       (busy)
`ifdef FP_ADD_ARB_STATS_EN
        ,
        .op_count    (op_count),
        .grant_count (grant_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic        sym;
        logic [31:0] exp_out;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Exact float encoding of a small integer (|v| < 2^24).
    function automatic logic [31:0] int_to_fp(input int v);
        logic        s;
        int unsigned m;
        int          p;
        s = (v < 0);
        m = s ? int'(-v) : v;
        if (m == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        return {s, 8'(127 + p), 23'((m << (23 - p)) & 32'h007F_FFFF)};
    endfunction

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive_lane(input int r, input logic [31:0] a, input logic [31:0] b, input logic sym);
        req_a[r*DW +: DW] = a;
        req_b[r*DW +: DW] = b;
        req_symbol[r]     = sym;
    endtask

    // One full operation on requester r with rsp_ready held high; returns to IDLE.
    task automatic run_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic sym,
                          output logic [31:0] out, output int id, output int lat);
        int n;
        out = 32'hDEAD_BEEF;
        id  = -1;
        lat = -1;
        @(posedge clk); #1;
        req_valid    = '0;
        req_valid[r] = 1'b1;
        drive_lane(r, a, b, sym);
        rsp_ready    = 1'b1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (req_ready[r]) break;
            n++;
        end
        check("grant_wait", 32'(n < 20), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        for (int m = 1; m <= 20; m++) begin
            @(negedge clk);
            if (rsp_valid) begin
                out = rsp_out;
                id  = int'(rsp_id);
                lat = m;
                break;
            end
        end
        $display("op req=%0d a=%08h b=%08h sym=%0d -> out=%08h id=%0d lat=%0d", r, a, b, sym, out, id, lat);
        @(posedge clk); #1;
    endtask

    // Watchdog: a hang is reported and the run stops.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    logic [31:0] o;
    int          id, lat, n, bad_stable, bad_rdy, bad_busy, vcount;
    logic [31:0] out0;
    int          id0;
    int          gids[$];
    int          gcyc[$];
    bit          pend;
    int          cnt, ptr, win, k, m_id;
    logic [31:0] m_out;
    logic [3:0]  exp_rdy;
    int          ra[NUM_REQ], rb[NUM_REQ];
    bit          rs[NUM_REQ];
`ifdef FP_ADD_ARB_STATS_EN
    int          sreq[5] = '{0, 1, 1, 2, 0};
    int          gexp[NUM_REQ];
`endif

    initial begin
        // Vector table: {requester, a, b, symbol, expected result}.
        vecs[0]  = '{0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000}; // 1+2
        vecs[1]  = '{2, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000}; // 3-1
        vecs[2]  = '{2, 32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000}; // tie, even stays
        vecs[3]  = '{3, 32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002}; // tie, odd rounds up
        vecs[4]  = '{0, 32'h3F80_0000, 32'h3380_0001, 1'b0, 32'h3F80_0001}; // above half
        vecs[5]  = '{1, 32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000}; // inf+1
        vecs[6]  = '{2, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000}; // inf-inf
        vecs[7]  = '{3, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'h7FC0_0000}; // NaN
        vecs[8]  = '{0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000}; // overflow
        vecs[9]  = '{1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000}; // x-x = +0
        vecs[10] = '{2, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000}; // -0 + -0
        vecs[11] = '{3, 32'h0000_0001, 32'h0000_0001, 1'b0, 32'h0000_0002}; // subnormals
        vecs[12] = '{0, 32'h0080_0000, 32'h0000_0001, 1'b1, 32'h007F_FFFF}; // into subnormal
        vecs[13] = '{1, 32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3380_0000}; // cancellation
        vecs[14] = '{2, 32'hC000_0000, 32'h3F80_0000, 1'b0, 32'hBF80_0000}; // -2+1
        vecs[15] = '{3, 32'h4B80_0000, 32'h3F80_0000, 1'b0, 32'h4B80_0000}; // 2^24+1
        vecs[16] = '{0, 32'h4B80_0000, 32'h4040_0000, 1'b0, 32'h4B80_0002}; // 2^24+3

        rst        = 1'b1;
        req_valid  = '0;
        req_symbol = '0;
        req_a      = '0;
        req_b      = '0;
        rsp_ready  = 1'b0;

        // Reset state.
        do_reset();
        @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_out",   rsp_out,        32'd0);
        check("reset_rsp_id",    32'(rsp_id),    32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);

        // Table-driven operations.
        for (int i = 0; i < 17; i++) begin
            run_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].sym, o, id, lat);
            check($sformatf("vec%0d_out", i), o, vecs[i].exp_out);
            check($sformatf("vec%0d_id", i), 32'(id), 32'(vecs[i].r));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        // Round-robin with all requesters continuously valid.
        do_reset();
        @(posedge clk); #1;
        for (int r = 0; r < NUM_REQ; r++) drive_lane(r, int_to_fp(r + 1), int_to_fp(10), 1'b0);
        req_valid = '1;
        rsp_ready = 1'b1;
        gids.delete();
        gcyc.delete();
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                check("rr_onehot", 32'($onehot(req_ready)), 32'd1);
                for (int r = 0; r < NUM_REQ; r++) if (req_ready[r]) gids.push_back(r);
                gcyc.push_back(c);
            end
        end
        check("rr_grant_count", 32'(gids.size() >= 5), 32'd1);
        if (gids.size() >= 5) begin
            for (int g = 0; g < 5; g++) begin
                check($sformatf("rr_grant%0d_id", g), 32'(gids[g]), 32'(g % NUM_REQ));
                if (g > 0) check($sformatf("rr_grant%0d_gap", g), 32'(gcyc[g] - gcyc[g-1]), 32'd3);
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        // Back-pressure: result held, no grants, busy high.
        do_reset();
        @(posedge clk); #1;
        drive_lane(1, int_to_fp(5), int_to_fp(7), 1'b0);
        drive_lane(3, int_to_fp(100), int_to_fp(1), 1'b1);
        req_valid = 4'b1010;
        rsp_ready = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            if (rsp_valid) break;
            n++;
        end
        check("bp_rsp_wait", 32'(n < 20), 32'd1);
        out0 = rsp_out;
        id0  = int'(rsp_id);
        check("bp_out", out0, int_to_fp(12));
        check("bp_id", 32'(id0), 32'd1);
        bad_stable = 0;
        bad_rdy    = 0;
        bad_busy   = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_out !== out0 || int'(rsp_id) != id0) bad_stable++;
            if (req_ready !== '0) bad_rdy++;
            if (busy !== 1'b1 || rsp_valid !== 1'b1) bad_busy++;
        end
        check("bp_stable_cycles", 32'(bad_stable), 32'd0);
        check("bp_ready_zero_cycles", 32'(bad_rdy), 32'd0);
        check("bp_busy_cycles", 32'(bad_busy), 32'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_still_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check("bp_after_valid", 32'(rsp_valid), 32'd0);
        check("bp_after_busy", 32'(busy), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        repeat (4) @(posedge clk);

        // Asynchronous reset during CALC.
        do_reset();
        run_op(2, int_to_fp(9), int_to_fp(4), 1'b0, o, id, lat);
        check("rm_first_out", o, int_to_fp(13));
        @(posedge clk); #1;
        drive_lane(3, int_to_fp(1), int_to_fp(1), 1'b0);
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("rm_grant3", 32'(req_ready), 32'b1000);
        @(posedge clk); #1;
        req_valid = '0;
        check("rm_calc_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rm_async_out", rsp_out, 32'd0);
        check("rm_async_id", 32'(rsp_id), 32'd0);
        check("rm_async_busy", 32'(busy), 32'd0);
        check("rm_async_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        vcount = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid) vcount++;
        end
        check("rm_no_stale_rsp", 32'(vcount), 32'd0);
        @(posedge clk); #1;
        req_valid = '1;
        @(negedge clk);
        check("rm_next_grant0", 32'(req_ready), 32'b0001);
        @(posedge clk); #1;
        req_valid = '0;

        // Randomized traffic against a transaction-level model.
        do_reset();
        pend = 1'b0;
        cnt  = 0;
        ptr  = 0;
        m_id = 0;
        m_out = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            ra[r] = 0;
            rb[r] = 0;
            rs[r] = 1'b0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(posedge clk); #1;
            for (int r = 0; r < NUM_REQ; r++) begin
                ra[r] = int'($urandom_range(0, 2097152)) - 1048576;
                rb[r] = int'($urandom_range(0, 2097152)) - 1048576;
                rs[r] = 1'($urandom_range(0, 1));
                drive_lane(r, int_to_fp(ra[r]), int_to_fp(rb[r]), rs[r]);
            end
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            win     = -1;
            exp_rdy = '0;
            if (!pend) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    k = (ptr + i) % NUM_REQ;
                    if (win < 0 && req_valid[k]) win = k;
                end
                if (win >= 0) exp_rdy[win] = 1'b1;
            end
            check("rnd_req_ready", 32'(req_ready), 32'(exp_rdy));
            check("rnd_busy", 32'(busy), 32'(pend));
            check("rnd_rsp_valid", 32'(rsp_valid), 32'(pend && cnt == 0));
            if (pend && cnt == 0) begin
                check("rnd_rsp_out", rsp_out, m_out);
                check("rnd_rsp_id", 32'(rsp_id), 32'(m_id));
            end
            if (pend) begin
                if (cnt > 0) begin
                    cnt--;
                end else if (rsp_ready) begin
                    pend = 1'b0;
                    $display("rnd txn id=%0d out=%08h", m_id, m_out);
                end
            end else if (win >= 0) begin
                pend  = 1'b1;
                cnt   = 1;
                ptr   = (win + 1) % NUM_REQ;
                m_id  = win;
                m_out = rs[win] ? int_to_fp(ra[win] - rb[win]) : int_to_fp(ra[win] + rb[win]);
            end
        end

`ifdef FP_ADD_ARB_STATS_EN
        // Statistics counters.
        do_reset();
        @(negedge clk);
        check("stats_reset_op_count", 32'(op_count), 32'd0);
        for (int r = 0; r < NUM_REQ; r++) gexp[r] = 0;
        for (int i = 0; i < 5; i++) begin
            run_op(sreq[i], int_to_fp(i + 1), int_to_fp(2), 1'b0, o, id, lat);
            gexp[sreq[i]]++;
        end
        check("stats_op_count", 32'(op_count), 32'd5);
        for (int r = 0; r < NUM_REQ; r++) begin
            check($sformatf("stats_grant_count%0d", r), 32'(grant_count[r*8 +: 8]), 32'(gexp[r]));
        end
        force dut.op_count = 16'hFFFE;
        @(posedge clk); #1;
        release dut.op_count;
        run_op(1, int_to_fp(1), int_to_fp(1), 1'b0, o, id, lat);
        check("stats_op_count_max", 32'(op_count), 32'h0000_FFFF);
        run_op(2, int_to_fp(1), int_to_fp(1), 1'b0, o, id, lat);
        check("stats_op_count_sat", 32'(op_count), 32'h0000_FFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_arbiter.md
Name: fp_add_arbiter

Overview:
- Shares one combinational single-precision floating-point add/subtract unit (instance of ADD) between NUM_REQ requesters.
- Requesters use a valid/ready handshake. Arbitration is round-robin.
- Operands and result are registered around the shared adder, so its combinational path is isolated from requester logic.
- Sits between the per-lane operand sources and the shared FP adder in the arithmetic datapath.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_WIDTH, 32: IEEE-754 single-precision word width; fixed at 32.
- ID_W, 2: width of requester index; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*DATA_WIDTH  operand A per requester; requester i uses slice i.
- req_b  in  NUM_REQ*DATA_WIDTH  operand B per requester.
- req_symbol  in  NUM_REQ  per-requester operation select: 0 = a+b, 1 = a-b.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  requester index owning the result.
- rsp_out  out  DATA_WIDTH  adder result.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset, asynchronous, any state: FSM to IDLE; rr_ptr=0; rsp_valid=0; rsp_out=0; rsp_id=0; operand registers=0; busy=0. An operation in flight is discarded, and no response is issued for it.
- IDLE:
  - req_ready[g] is driven combinationally high for the winner g: the first requester with req_valid set, searching upward from rr_ptr with wrap-around.
  - req_ready is all zero when no requester is valid, and all zero in every non-IDLE state.
  - On a handshake (req_valid[g] & req_ready[g]): capture op_a, op_b, op_sym and id=g; set rr_ptr=(g+1) mod NUM_REQ; go to CALC.
  - With no valid request, stay in IDLE; rr_ptr is unchanged.
- CALC: the adder evaluates the registered operands. At the clock edge: rsp_out <= adder result; rsp_id <= id; rsp_valid <= 1; go to HOLD.
- HOLD:
  - rsp_valid=1. rsp_out and rsp_id are held stable until the handshake.
  - On rsp_ready: rsp_valid <= 0 and go to IDLE.
  - Back-pressure may last indefinitely, and requests are not accepted meanwhile.
- Latency: request handshake at cycle N; rsp_valid high from cycle N+2. Minimum throughput is one operation per 3 cycles when rsp_ready is held high.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that is denied keeps req_valid high and is served within NUM_REQ grants (no starvation).
- req_valid deasserting in IDLE before the handshake is allowed (no stickiness); arbitration is simply re-evaluated.
- Special IEEE cases (zero, inf, NaN) are handled entirely by the adder; the arbiter never inspects data.
- rr_ptr wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: FP_ADD_ARB_STATS_EN.
- With the macro defined:
  - Adds output op_count [15:0]: a count of completed response handshakes.
  - Saturates at 16'hFFFF; reset value 0.
  - Adds output grant_count [NUM_REQ*8-1:0]: per-requester 8-bit wrap-around counters of request handshakes.
- Without the macro: these ports and their counters are absent. Core behaviour is identical.

Decomposition:
- Package fp_add_pkg: FSM state encoding (IDLE=2'd0, CALC=2'd1, HOLD=2'd2), the DATA_WIDTH constant, and the op-select constants OP_ADD=1'b0 and OP_SUB=1'b1.
- Sub-module rr_arbiter: parameter NUM_REQ; inputs req and ptr; outputs one-hot gnt and encoded gnt_id. Purely combinational.
- The FSM, registers and ADD instance live in fp_add_arbiter.

Test Plan:
- Single op: req 0 with a=0x3F800000, b=0x40000000, symbol=0, rsp_ready=1 -> rsp_valid 2 cycles after the handshake; rsp_out=0x40400000; rsp_id=0.
- Subtract: req 2 with a=0x40400000, b=0x3F800000, symbol=1 -> rsp_out=0x40000000; rsp_id=2.
- Round-robin: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0; each grant 3 cycles apart.
- Back-pressure: rsp_ready=0 for 10 cycles with other requests pending -> rsp_out and rsp_id stable; req_ready all zero; busy=1. Raising rsp_ready -> IDLE the next cycle, then a new grant.
- Reset mid-op: assert rst during CALC -> outputs are zero immediately (asynchronous); no rsp_valid after release; next grant goes to requester 0.
- STATS_EN build: 5 completed ops -> op_count=5; grant_count matches the per-requester grants. Counter saturation is checked by forcing the count to 0xFFFE.
